// File: rtl/ram4x8_pkg.sv
// Shared definitions for the ram4x8 arbiter: state encoding, default widths, requester IDs.
package ram4x8_pkg;

  localparam int RAM_AW = 2;
  localparam int RAM_DW = 8;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the requester not served last wins a tie.
module rr_arb2
  import ram4x8_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_served,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = a_req | b_req;
    grant_id    = REQ_A;
    if (a_req && b_req) begin
      grant_id = (last_served == REQ_A) ? REQ_B : REQ_A;
    end else if (b_req) begin
      grant_id = REQ_B;
    end
  end

endmodule

// File: rtl/ram4x8_arbiter.sv
// Sequencer/arbiter sharing one ram4x8 port between requesters A and B.
// State | meaning: INIT clear sweep | IDLE arbitrate | ACCESS drive RAM | RESP ack granted side
module ram4x8_arbiter
  import ram4x8_pkg::*;
#(
  parameter int AW            = RAM_AW,
  parameter int DW            = RAM_DW,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          ram_write,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ready
);

  localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic          r_last;
  logic          r_gid;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_a_rdata, r_b_rdata;
  logic          w_a_req_m, w_b_req_m;
  logic          w_grant_valid, w_grant_id, w_grant_en;
  logic          w_in_init;

  // The side being acked in RESP is masked so a still-held req cannot win again.
  assign w_a_req_m = a_req && !(r_state == S_RESP && r_gid == REQ_A);
  assign w_b_req_m = b_req && !(r_state == S_RESP && r_gid == REQ_B);

  rr_arb2 u_arb (
    .a_req       (w_a_req_m),
    .b_req       (w_b_req_m),
    .last_served (r_last),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    case (r_state)
      S_INIT:   if (r_cnt == CNT_LAST) w_state_nxt = S_IDLE;
      S_IDLE, S_RESP: begin
        w_state_nxt = S_IDLE;
        if (w_grant_valid) begin
          w_state_nxt = S_ACCESS;
          w_grant_en  = 1'b1;
        end
      end
      S_ACCESS: w_state_nxt = S_RESP;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state <= INIT_ON_RESET ? S_INIT : S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_cnt     <= '0;
      r_last    <= REQ_B;
      r_gid     <= REQ_A;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      if (r_state == S_INIT) r_cnt <= r_cnt + AW'(1);
      if (w_grant_en) begin
        r_gid   <= w_grant_id;
        r_we    <= (w_grant_id == REQ_A) ? a_we    : b_we;
        r_addr  <= (w_grant_id == REQ_A) ? a_addr  : b_addr;
        r_wdata <= (w_grant_id == REQ_A) ? a_wdata : b_wdata;
      end
      if (r_state == S_ACCESS) begin
        r_last <= r_gid;
        if (!r_we && r_gid == REQ_A) r_a_rdata <= ram_dout;
        if (!r_we && r_gid == REQ_B) r_b_rdata <= ram_dout;
      end
    end
  end

  // Reset state is INIT, so sweep outputs are qualified by clear to stay 0 while held in reset.
  assign w_in_init = (r_state == S_INIT) && clear;

  always_comb begin
    ram_write = w_in_init || (r_state == S_ACCESS && r_we);
    ram_addr  = '0;
    ram_din   = '0;
    if (w_in_init) begin
      ram_addr = r_cnt;
    end else if (r_state == S_ACCESS) begin
      ram_addr = r_addr;
      if (r_we) ram_din = r_wdata;
    end
  end

  assign a_ack   = (r_state == S_RESP) && (r_gid == REQ_A);
  assign b_ack   = (r_state == S_RESP) && (r_gid == REQ_B);
  assign a_rdata = r_a_rdata;
  assign b_rdata = r_b_rdata;
  assign ready   = (r_state != S_INIT) && clear;

endmodule

// File: tb/tb_ram4x8_arbiter.sv
// Bench for ram4x8_arbiter: behavioural RAM, directed scenarios, then random two-requester traffic.
`timescale 1ns/1ps
module tb_ram4x8_arbiter;

  localparam int AW = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          clear;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, b_ack;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_write;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ready;

  logic [DW-1:0] mem [4];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign ram_dout = mem[ram_addr];
  always @(posedge clk) if (ram_write) mem[ram_addr] <= ram_din;

  ram4x8_arbiter #(.AW(AW), .DW(DW), .INIT_ON_RESET(1'b1)) dut (
    .clk(clk), .clear(clear),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_write(ram_write), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout), .ready(ready)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk_eq({tag, "_acks"}, {a_ack, b_ack}, 2'b00);
    chk_eq({tag, "_ramw"}, ram_write, 1'b0);
    chk_eq({tag, "_addr"}, ram_addr, 0);
    chk_eq({tag, "_din"}, ram_din, 0);
    chk_eq({tag, "_rdy"}, ready, 1'b0);
  endtask

  // Hold reset over one edge, release just after a rising edge, then follow the clear sweep.
  task automatic reset_and_sweep(input string tag);
    clear = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge clk);
    check_quiet({tag, "_rst"});
    chk_eq({tag, "_rst_rd"}, {a_rdata, b_rdata}, 16'h0000);
    @(posedge clk);
    #1 clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_eq({tag, "_init_w"}, ram_write, 1'b1);
      chk_eq({tag, "_init_a"}, ram_addr, i);
      chk_eq({tag, "_init_d"}, ram_din, 0);
      chk_eq({tag, "_init_rdy_ack"}, {ready, a_ack, b_ack}, 3'b000);
    end
    @(negedge clk);
    chk_eq({tag, "_ready"}, {ready, ram_write}, 2'b10);
  endtask

  // Single transaction from an idle arbiter; ack must land exactly two cycles after the request.
  task automatic run_one(input string tag, input logic who, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, output logic [DW-1:0] rd);
    int n;
    @(negedge clk);
    if (who == 1'b0) begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    else             begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(who ? b_ack : a_ack) && n < 10);
    chk_eq({tag, "_lat"}, n, 2);
    chk_eq({tag, "_other_ack"}, who ? a_ack : b_ack, 1'b0);
    rd = who ? b_rdata : a_rdata;
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  // Both requesters raise together; returns ack cycle numbers and rdata seen at each ack.
  task automatic run_pair(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                          input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                          output int ta, output int tb, output logic [DW-1:0] ra, output logic [DW-1:0] rb);
    ta = -1; tb = -1; ra = '0; rb = '0;
    @(negedge clk);
    a_req = 1'b1; a_we = wa; a_addr = aa; a_wdata = da;
    b_req = 1'b1; b_we = wb; b_addr = ab; b_wdata = db;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (a_ack && b_ack) chk_eq("pair_both_ack", {a_ack, b_ack}, 2'b10);
      if (a_ack) begin ta = n; ra = a_rdata; a_req = 1'b0; end
      if (b_ack) begin tb = n; rb = b_rdata; b_req = 1'b0; end
      if (ta >= 0 && tb >= 0) break;
    end
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  logic [DW-1:0] rd, ra, rb;
  int            ta, tb;

  // Random-phase model: shadow memory plus per-requester pending transactions.
  logic [DW-1:0] shadow [4];
  logic          pa, pb;
  int            age_a, age_b;
  logic [DW-1:0] exp_ard, exp_brd;

  initial begin
    clear = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

    reset_and_sweep("t1");

    run_one("t2_wr", 1'b0, 1'b1, 2'd2, 8'hC3, rd);
    run_one("t2_rd", 1'b0, 1'b0, 2'd2, 8'h00, rd);
    chk_eq("t2_rdata", rd, 8'hC3);

    run_one("t4_rd", 1'b1, 1'b0, 2'd0, 8'h00, rd);
    chk_eq("t4_brdata", rd, 8'h00);
    chk_eq("t4_ardata_kept", a_rdata, 8'hC3);

    // last served is B here, so A wins the tie
    run_pair(1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, ta, tb, ra, rb);
    chk_eq("t3_a_first", ta, 2);
    chk_eq("t3_b_second", tb, 4);
    run_one("t3_a_single", 1'b0, 1'b0, 2'd3, 8'h00, rd);
    chk_eq("t3_rd3", rd, 8'h33);
    // last served is now A, so B wins the next tie
    run_pair(1'b0, 2'd2, 8'h00, 1'b0, 2'd1, 8'h00, ta, tb, ra, rb);
    chk_eq("t3b_b_first", tb, 2);
    chk_eq("t3b_a_second", ta, 4);
    chk_eq("t3b_b_rd1", rb, 8'h11);
    chk_eq("t3b_a_rd2", ra, 8'hC3);

    // Request raised during INIT is held and served once the sweep finishes.
    begin
      int rdy_at, ack_at, early;
      clear = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1 clear = 1'b1;
      rdy_at = -1; ack_at = -1; early = 0;
      for (int n = 0; n < 12; n++) begin
        @(negedge clk);
        if (!ready && (a_ack || b_ack)) early++;
        if (ready && rdy_at < 0) rdy_at = n;
        if (a_ack) begin ack_at = n; a_req = 1'b0; break; end
        if (n == 1) begin a_req = 1'b1; a_we = 1'b0; a_addr = 2'd2; end
      end
      chk_eq("t5_early_ack", early, 0);
      chk_eq("t5_ready_at", rdy_at, 4);
      chk_eq("t5_ack_after_idle", ack_at - rdy_at, 2);
      chk_eq("t5_rdata", a_rdata, 8'h00);
    end

    run_one("t6_prep", 1'b1, 1'b1, 2'd1, 8'h5A, rd);
    // Reset lands in the middle of B's write ACCESS.
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 2'd1; b_wdata = 8'hFF;
    @(negedge clk);
    chk_eq("t6_access", {ram_write, ram_addr, ram_din}, {1'b1, 2'd1, 8'hFF});
    #2 clear = 1'b0;
    b_req = 1'b0;
    #1 check_quiet("t6_async");
    reset_and_sweep("t6");
    run_one("t6_rd", 1'b1, 1'b0, 2'd1, 8'h00, rd);
    chk_eq("t6_rd1", rd, 8'h00);

    // Random traffic after a fresh sweep; the model works at transaction level.
    reset_and_sweep("rnd");
    for (int i = 0; i < 4; i++) shadow[i] = '0;
    pa = 1'b0; pb = 1'b0; age_a = 0; age_b = 0;
    exp_ard = a_rdata; exp_brd = b_rdata;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (a_ack && b_ack) chk_eq("rnd_dual_ack", {a_ack, b_ack}, 2'b10);
      if (pa) age_a++;
      if (pb) age_b++;
      if (a_ack) begin
        chk_eq("rnd_a_pending", pa, 1'b1);
        chk_eq("rnd_a_lat_ok", (age_a >= 2 && age_a <= 4), 1'b1);
        if (a_we) shadow[a_addr] = a_wdata;
        else      exp_ard = shadow[a_addr];
        chk_eq("rnd_a_rdata", a_rdata, exp_ard);
        pa = 1'b0; a_req = 1'b0;
      end
      if (b_ack) begin
        chk_eq("rnd_b_pending", pb, 1'b1);
        chk_eq("rnd_b_lat_ok", (age_b >= 2 && age_b <= 4), 1'b1);
        if (b_we) shadow[b_addr] = b_wdata;
        else      exp_brd = shadow[b_addr];
        chk_eq("rnd_b_rdata", b_rdata, exp_brd);
        pb = 1'b0; b_req = 1'b0;
      end
      if (pa && age_a > 8) begin chk_eq("rnd_a_timeout", age_a, 4); pa = 1'b0; a_req = 1'b0; end
      if (pb && age_b > 8) begin chk_eq("rnd_b_timeout", age_b, 4); pb = 1'b0; b_req = 1'b0; end
      if (!pa && !a_ack && $urandom_range(0, 2) == 0) begin
        pa = 1'b1; age_a = 0; a_req = 1'b1;
        a_we = 1'($urandom); a_addr = AW'($urandom); a_wdata = DW'($urandom);
      end
      if (!pb && !b_ack && $urandom_range(0, 2) == 0) begin
        pb = 1'b1; age_b = 0; b_req = 1'b1;
        b_we = 1'($urandom); b_addr = AW'($urandom); b_wdata = DW'($urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
